// File: rtl/apb_fb_pkg.sv
// Shared definitions for the APB framebuffer pixel packer: register map,
// CTRL bit positions, master FSM encoding and frame geometry.
package apb_fb_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PIXEL  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_START  = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2
  } mst_state_t;

  localparam int FRAME_WORDS = 196;

  function automatic int frame_words(input int frame_bytes);
    return frame_bytes / 4;
  endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous packed-word FIFO; a push while full is accepted when a pop
// happens in the same cycle. clr empties it synchronously.
module fb_word_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_fb_pixel_packer.sv
// Packs CPU-written 8-bit pixels into 32-bit words and streams them as APB
// master writes into the framebuffer. Optional frame_irq via PACKER_FRAME_IRQ_EN.
module apb_fb_pixel_packer
  import apb_fb_pkg::*;
#(
  parameter int FRAME_BYTES = 784,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 10
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic [3:2]        PADDR,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              M_PSEL,
  output logic              M_PENABLE,
  output logic              M_PWRITE,
  output logic [ADDR_W-1:0] M_PADDR,
  output logic [31:0]       M_PWDATA,
  input  logic              M_PREADY
`ifdef PACKER_FRAME_IRQ_EN
  ,
  output logic              frame_irq
`endif
);

  localparam int FW = frame_words(FRAME_BYTES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FW - 1);

  logic              wr_setup;
  logic              ctrl_wr;
  logic              pix_wr;
  logic              start;
  logic              flush;
  logic              pix_last;
  logic              push;
  logic [31:0]       push_data;
  logic              pop;
  logic              xfer_done;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] next_addr;

  logic [31:0]       pack_buf;
  logic [1:0]        lane;
  logic              overflow;
  logic              frame_done;
  logic              start_pend;
  logic [ADDR_W-1:0] wptr;
  mst_state_t        state;

  logic [31:0]       f_rdata;
  logic              f_full;
  logic              f_empty;
  logic [CW-1:0]     f_count;
  logic              irq_en_bit;
  logic [31:0]       status;
  logic              unused_pwdata;

  assign PREADY        = 1'b1;
  assign PSLVERR       = 1'b0;
  assign unused_pwdata = ^PWDATA[31:8];

  assign wr_setup = PSEL & PWRITE & ~PENABLE;
  assign ctrl_wr  = wr_setup & (PADDR == REG_CTRL);
  assign pix_wr   = wr_setup & (PADDR == REG_PIXEL);
  assign start    = ctrl_wr & PWDATA[CTRL_START];
  assign flush    = ctrl_wr & PWDATA[CTRL_FLUSH] & ~PWDATA[CTRL_START];
  assign pix_last = pix_wr & (lane == 2'd3);

  // A flush pushes the partial word; unfilled lanes are already zero.
  assign push      = pix_last | (flush & (lane != 2'd0));
  assign push_data = pix_last ? {PWDATA[7:0], pack_buf[23:0]} : pack_buf;

  // START suppresses pops so the FIFO clear cannot race a launch.
  assign xfer_done = (state == M_ACCESS) & M_PREADY;
  assign pop       = ~f_empty & ~start & ((state == M_IDLE) | xfer_done);
  assign ptr_inc   = (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
  assign next_addr = start_pend ? '0 : ptr_inc;

  fb_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .clr   (start),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      pack_buf <= '0;
      lane     <= '0;
      overflow <= 1'b0;
    end else begin
      if (start) begin
        pack_buf <= '0;
        lane     <= '0;
      end else if (pix_wr) begin
        if (lane == 2'd3) begin
          pack_buf <= '0;
          lane     <= '0;
        end else begin
          pack_buf[{lane, 3'b000} +: 8] <= PWDATA[7:0];
          lane <= lane + 1'b1;
        end
      end else if (flush && lane != 2'd0) begin
        pack_buf <= '0;
        lane     <= '0;
      end

      if (start)
        overflow <= 1'b0;
      else if (push && f_full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state      <= M_IDLE;
      M_PSEL     <= 1'b0;
      M_PENABLE  <= 1'b0;
      M_PWRITE   <= 1'b0;
      M_PADDR    <= '0;
      M_PWDATA   <= '0;
      wptr       <= '0;
      start_pend <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        M_IDLE: begin
          if (pop) begin
            state     <= M_SETUP;
            M_PSEL    <= 1'b1;
            M_PWRITE  <= 1'b1;
            M_PENABLE <= 1'b0;
            M_PADDR   <= wptr;
            M_PWDATA  <= f_rdata;
          end
        end
        M_SETUP: begin
          state     <= M_ACCESS;
          M_PENABLE <= 1'b1;
        end
        M_ACCESS: begin
          if (M_PREADY) begin
            if (pop) begin
              state     <= M_SETUP;
              M_PENABLE <= 1'b0;
              M_PADDR   <= next_addr;
              M_PWDATA  <= f_rdata;
            end else begin
              state     <= M_IDLE;
              M_PSEL    <= 1'b0;
              M_PENABLE <= 1'b0;
              M_PWRITE  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= M_IDLE;
          M_PSEL    <= 1'b0;
          M_PENABLE <= 1'b0;
          M_PWRITE  <= 1'b0;
        end
      endcase

      // An in-flight transfer finishes at its own address; the restart to
      // word 0 is deferred until it completes.
      if (start) begin
        frame_done <= 1'b0;
        if (state == M_IDLE || xfer_done) begin
          wptr       <= '0;
          start_pend <= 1'b0;
        end else begin
          start_pend <= 1'b1;
        end
      end else if (xfer_done) begin
        wptr       <= next_addr;
        start_pend <= 1'b0;
        if (!start_pend && wptr == LAST_ADDR)
          frame_done <= 1'b1;
      end
    end
  end

`ifdef PACKER_FRAME_IRQ_EN
  logic irq_en;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      irq_en    <= 1'b0;
      frame_irq <= 1'b0;
    end else begin
      if (ctrl_wr)
        irq_en <= PWDATA[CTRL_IRQ_EN];
      frame_irq <= start ? 1'b0 : (frame_done & irq_en);
    end
  end

  assign irq_en_bit = irq_en;
`else
  assign irq_en_bit = 1'b0;
`endif

  always_comb begin
    status        = '0;
    status[0]     = (state != M_IDLE) | ~f_empty;
    status[1]     = frame_done;
    status[2]     = f_full;
    status[3]     = overflow;
    status[4]     = irq_en_bit;
    status[8:5]   = 4'(f_count);
    status[10:9]  = lane;
    status[25:16] = 10'(wptr);
  end

  assign PRDATA = (PSEL && !PWRITE && PADDR == REG_STATUS) ? status : 32'h0;

endmodule

// File: tb/tb_apb_fb_pixel_packer.sv
// Directed self-checking bench for apb_fb_pixel_packer; observes master
// writes through a completion monitor and reads STATUS over the slave port.
module tb_apb_fb_pixel_packer;

  logic        PCLK;
  logic        PRESETN;
  logic        PSEL;
  logic [3:2]  PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        M_PSEL;
  logic        M_PENABLE;
  logic        M_PWRITE;
  logic [9:0]  M_PADDR;
  logic [31:0] M_PWDATA;
  logic        M_PREADY;
`ifdef PACKER_FRAME_IRQ_EN
  logic        frame_irq;
`endif

  int checks;
  int failures;

  logic [9:0]  q_addr[$];
  logic [31:0] q_data[$];

  apb_fb_pixel_packer #(
    .FRAME_BYTES (784),
    .FIFO_DEPTH  (8),
    .ADDR_W      (10)
  ) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .PSEL      (PSEL),
    .PADDR     (PADDR),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .M_PSEL    (M_PSEL),
    .M_PENABLE (M_PENABLE),
    .M_PWRITE  (M_PWRITE),
    .M_PADDR   (M_PADDR),
    .M_PWDATA  (M_PWDATA),
    .M_PREADY  (M_PREADY)
`ifdef PACKER_FRAME_IRQ_EN
    ,
    .frame_irq (frame_irq)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (PRESETN && M_PSEL && M_PENABLE && M_PREADY) begin
      q_addr.push_back(M_PADDR);
      q_data.push_back(M_PWDATA);
    end
  end

  task automatic apb_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic pix(input logic [7:0] v);
    apb_wr(2'd1, {24'h0, v});
  endtask

  task automatic ctrl(input logic [31:0] v);
    apb_wr(2'd0, v);
  endtask

  task automatic rd_status(output logic [31:0] v);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 2'd2;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    v = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_enable();
    for (int i = 0; i < 60 && M_PENABLE !== 1'b1; i++) @(negedge PCLK);
  endtask

  task automatic test_reset();
    logic [31:0] st;
    PRESETN = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    M_PREADY = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({M_PSEL, M_PENABLE, M_PWRITE} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl got=%b want=000", {M_PSEL, M_PENABLE, M_PWRITE});
    end
    checks++;
    if (M_PADDR !== 10'd0 || M_PWDATA !== 32'd0) begin
      failures++; $display("FAIL reset_addr_data got=%h/%h want=0/0", M_PADDR, M_PWDATA);
    end
    checks++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      failures++; $display("FAIL reset_slv_resp got=%b%b want=10", PREADY, PSLVERR);
    end
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    rd_status(st);
    checks++;
    if (st !== 32'h0) begin
      failures++; $display("FAIL reset_status got=%h want=00000000", st);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] st;
    q_addr.delete(); q_data.delete();
    M_PREADY = 1'b1;
    pix(8'h11); pix(8'h22); pix(8'h33);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 2'd1; PWDATA = 32'h44;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    checks++;
    if (M_PSEL !== 1'b0) begin
      failures++; $display("FAIL lat_psel_early got=%b want=0", M_PSEL);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    checks++;
    if ({M_PSEL, M_PENABLE, M_PWRITE} !== 3'b101 || M_PADDR !== 10'd0 || M_PWDATA !== 32'h44332211) begin
      failures++;
      $display("FAIL lat_setup got=%b addr=%h data=%h want=101 addr=000 data=44332211",
               {M_PSEL, M_PENABLE, M_PWRITE}, M_PADDR, M_PWDATA);
    end
    @(posedge PCLK); #1;
    checks++;
    if ({M_PSEL, M_PENABLE} !== 2'b11) begin
      failures++; $display("FAIL lat_access got=%b want=11", {M_PSEL, M_PENABLE});
    end
    repeat (6) @(posedge PCLK);
    checks++;
    if (q_addr.size() != 1 || q_addr[0] !== 10'd0 || q_data[0] !== 32'h44332211) begin
      failures++; $display("FAIL single_xfer count=%0d want=1 addr0 data 44332211", q_addr.size());
    end
    rd_status(st);
    checks++;
    if (st !== 32'h0001_0000) begin
      failures++; $display("FAIL single_status got=%h want=00010000", st);
    end
  endtask

  task automatic test_frame();
    logic [31:0] st;
    logic [31:0] exp_st;
    logic [31:0] w;
    int bad;
    ctrl(32'h5);
    q_addr.delete(); q_data.delete();
    M_PREADY = 1'b1;
    for (int i = 0; i < 784; i++) pix(8'(i));
    repeat (20) @(posedge PCLK);
    checks++;
    if (q_addr.size() != 196) begin
      failures++; $display("FAIL frame_count got=%0d want=196", q_addr.size());
    end
    bad = 0;
    for (int k = 0; k < q_addr.size() && k < 196; k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      if (q_addr[k] !== 10'(k) || q_data[k] !== w) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL frame_words bad=%0d want=0", bad);
    end
    rd_status(st);
`ifdef PACKER_FRAME_IRQ_EN
    exp_st = 32'h12;
`else
    exp_st = 32'h02;
`endif
    checks++;
    if (st !== exp_st) begin
      failures++; $display("FAIL frame_status got=%h want=%h", st, exp_st);
    end
`ifdef PACKER_FRAME_IRQ_EN
    checks++;
    if (frame_irq !== 1'b1) begin
      failures++; $display("FAIL frame_irq got=%b want=1", frame_irq);
    end
`endif
  endtask

  task automatic test_stall_overflow();
    logic [31:0] st;
    logic [31:0] w;
    int bad;
    ctrl(32'h1);
    q_addr.delete(); q_data.delete();
    M_PREADY = 1'b0;
    for (int i = 0; i < 40; i++) pix(8'(i));
    checks++;
    if ({M_PSEL, M_PENABLE} !== 2'b11 || M_PADDR !== 10'd0 || M_PWDATA !== 32'h03020100) begin
      failures++;
      $display("FAIL stall_hold got=%b addr=%h data=%h want=11 addr=000 data=03020100",
               {M_PSEL, M_PENABLE}, M_PADDR, M_PWDATA);
    end
    rd_status(st);
    checks++;
    if (st !== 32'h0000_010D) begin
      failures++; $display("FAIL stall_status got=%h want=0000010d", st);
    end
    M_PREADY = 1'b1;
    repeat (40) @(posedge PCLK);
    checks++;
    if (q_addr.size() != 9) begin
      failures++; $display("FAIL stall_count got=%0d want=9", q_addr.size());
    end
    bad = 0;
    for (int k = 0; k < q_addr.size() && k < 9; k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      if (q_addr[k] !== 10'(k) || q_data[k] !== w) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL stall_words bad=%0d want=0", bad);
    end
    rd_status(st);
    checks++;
    if (st !== 32'h0009_0008) begin
      failures++; $display("FAIL stall_drained_status got=%h want=00090008", st);
    end
  endtask

  task automatic test_flush();
    logic [31:0] st;
    ctrl(32'h1);
    q_addr.delete(); q_data.delete();
    M_PREADY = 1'b1;
    pix(8'hAA); pix(8'hBB);
    rd_status(st);
    checks++;
    if (st !== 32'h0000_0400) begin
      failures++; $display("FAIL flush_lane_before got=%h want=00000400", st);
    end
    ctrl(32'h2);
    repeat (8) @(posedge PCLK);
    checks++;
    if (q_addr.size() != 1 || q_addr[0] !== 10'd0 || q_data[0] !== 32'h0000BBAA) begin
      failures++; $display("FAIL flush_word count=%0d want=1 addr0 data 0000bbaa", q_addr.size());
    end
    rd_status(st);
    checks++;
    if (st !== 32'h0001_0000) begin
      failures++; $display("FAIL flush_status got=%h want=00010000", st);
    end
    ctrl(32'h2);
    repeat (8) @(posedge PCLK);
    checks++;
    if (q_addr.size() != 1) begin
      failures++; $display("FAIL flush_empty count=%0d want=1", q_addr.size());
    end
  endtask

  task automatic test_start_mid();
    logic [31:0] st;
    ctrl(32'h1);
    M_PREADY = 1'b1;
    for (int i = 0; i < 20; i++) pix(8'(i));
    repeat (10) @(posedge PCLK);
    q_addr.delete(); q_data.delete();
    M_PREADY = 1'b0;
    pix(8'h50); pix(8'h51); pix(8'h52); pix(8'h53);
    pix(8'h60); pix(8'h61); pix(8'h62); pix(8'h63);
    pix(8'h70); pix(8'h71);
    wait_enable();
    checks++;
    if (M_PENABLE !== 1'b1 || M_PADDR !== 10'd5) begin
      failures++; $display("FAIL startmid_access en=%b addr=%0d want=1 addr=5", M_PENABLE, M_PADDR);
    end
    ctrl(32'h1);
    rd_status(st);
    checks++;
    if (st !== 32'h0005_0001) begin
      failures++; $display("FAIL startmid_status got=%h want=00050001", st);
    end
    M_PREADY = 1'b1;
    repeat (10) @(posedge PCLK);
    checks++;
    if (q_addr.size() != 1 || q_addr[0] !== 10'd5 || q_data[0] !== 32'h53525150) begin
      failures++; $display("FAIL startmid_complete count=%0d want=1 addr5 data 53525150", q_addr.size());
    end
    rd_status(st);
    checks++;
    if (st !== 32'h0) begin
      failures++; $display("FAIL startmid_after got=%h want=00000000", st);
    end
    pix(8'h81); pix(8'h82); pix(8'h83); pix(8'h84);
    repeat (8) @(posedge PCLK);
    checks++;
    if (q_addr.size() != 2 || q_addr[1] !== 10'd0 || q_data[1] !== 32'h84838281) begin
      failures++; $display("FAIL startmid_restart count=%0d want=2 addr0 data 84838281", q_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] st;
    M_PREADY = 1'b0;
    pix(8'h01); pix(8'h02); pix(8'h03); pix(8'h04);
    wait_enable();
    checks++;
    if ({M_PSEL, M_PENABLE} !== 2'b11) begin
      failures++; $display("FAIL rstmid_access got=%b want=11", {M_PSEL, M_PENABLE});
    end
    @(posedge PCLK); #2;
    PRESETN = 1'b0;
    #1;
    checks++;
    if ({M_PSEL, M_PENABLE, M_PWRITE} !== 3'b000) begin
      failures++; $display("FAIL rstmid_async got=%b want=000", {M_PSEL, M_PENABLE, M_PWRITE});
    end
    M_PREADY = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETN = 1'b1;
    rd_status(st);
    checks++;
    if (st !== 32'h0 || M_PSEL !== 1'b0) begin
      failures++; $display("FAIL rstmid_status got=%h psel=%b want=00000000 psel=0", st, M_PSEL);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_word();
    test_frame();
    test_stall_overflow();
    test_flush();
    test_start_mid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_fb_pixel_packer.md
Name: apb_fb_pixel_packer

Overview:
- Upstream feeder for the HDMI framebuffer peripheral.
- The CPU writes 8-bit grey pixels one at a time through an APB slave port.
- The block packs four pixels per 32-bit little-endian word, buffers the words in a small FIFO, and streams them as APB master writes into the framebuffer at sequential word addresses.
- After the last word of a frame, the address wraps to 0 and a frame-done status is raised.

Parameters:
FRAME_BYTES, 784, frame size in bytes; must be a multiple of 4; FRAME_WORDS = FRAME_BYTES/4 (196).
FIFO_DEPTH, 8, packed-word FIFO depth; must be a power of 2.
ADDR_W, 10, word-address width of the master port (matches framebuffer PADDR[11:2]).

Ports:
PCLK  in  1  single clock for both APB ports
PRESETN  in  1  asynchronous active-low reset
PSEL  in  1  slave select
PADDR  in  [3:2]  slave register select: 0 CTRL, 1 PIXEL, 2 STATUS
PENABLE  in  1  slave enable
PWRITE  in  1  slave write
PWDATA  in  32  slave write data
PRDATA  out  32  slave read data
PREADY  out  1  constant 1
PSLVERR  out  1  constant 0
M_PSEL  out  1  master select to framebuffer
M_PENABLE  out  1  master enable
M_PWRITE  out  1  constant 1 while M_PSEL is high, else 0
M_PADDR  out  ADDR_W  word address
M_PWDATA  out  32  packed pixel word
M_PREADY  in  1  framebuffer ready

Behaviour:
- Reset: all registers asynchronously cleared.
  - M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA = 0; PRDATA = 0.
  - FIFO empty, lane count 0, word pointer 0, all status bits 0.
- Slave write decode: a write takes effect on the setup-phase cycle (PSEL & PWRITE & ~PENABLE). There are no wait states.
- Slave read: PRDATA is combinational = STATUS when PSEL & ~PWRITE & PADDR==2; otherwise 0.
- CTRL write (bit 0 START, bit 1 FLUSH, bit 2 IRQ_EN; START has priority over FLUSH):
  - START: clears FIFO, pack buffer, lane count, frame_done and overflow.
    - If a master transfer is in SETUP or ACCESS, it completes to its original address with its latched data.
    - The word pointer becomes 0 when that transfer completes (start_pend flag); otherwise it becomes 0 immediately.
  - FLUSH: if lane count ≠ 0, pushes the pack buffer with the unfilled upper bytes zero and resets lane count to 0. If lane count = 0, no effect.
- PIXEL write: PWDATA[7:0] is stored into byte lane 'lane', and lane increments.
  - When the 4th byte arrives, the word is pushed to the FIFO on the same edge and lane returns to 0.
- FIFO push while full: the word is dropped and sticky overflow is set, unless a pop occurs in the same cycle, in which case the push is accepted.
- Master FSM (IDLE, SETUP, ACCESS):
  - IDLE -> SETUP when FIFO is non-empty. On entry: pop FIFO, latch M_PWDATA = head, M_PADDR = word pointer; M_PSEL = 1, M_PENABLE = 0.
  - SETUP -> ACCESS unconditionally; M_PENABLE = 1. Address and data are held stable.
  - ACCESS: holds while M_PREADY = 0. On M_PREADY = 1 the transfer completes:
    - Word pointer increments; if the completed address = FRAME_WORDS-1, the pointer wraps to 0 and frame_done is set.
    - If FIFO is non-empty, go to SETUP with the next pop (back-to-back transfers, M_PSEL stays high). Otherwise go to IDLE with M_PSEL and M_PENABLE = 0.
- Latency: 4th PIXEL write in setup cycle T -> FIFO non-empty at T+1 -> M_PSEL high at T+2 -> M_PENABLE high at T+3.
- STATUS layout:
  - [0] busy (FSM ≠ IDLE or FIFO non-empty)
  - [1] frame_done
  - [2] fifo_full
  - [3] overflow
  - [4] IRQ_EN
  - [8:5] fifo count
  - [10:9] lane
  - [25:16] word pointer
  - all other bits 0
- Reset mid-transfer: M_PSEL and M_PENABLE drop asynchronously; the in-flight word is lost.

Optional Feature:
- Macro: PACKER_FRAME_IRQ_EN.
- Defined: adds output port frame_irq (1 bit), registered, = frame_done & IRQ_EN; reset 0; cleared by START.
- Undefined: no port; CTRL bit 2 is ignored and STATUS[4] reads 0.

Decomposition:
- Shared package apb_fb_pkg:
  - register offsets (CTRL, PIXEL, STATUS)
  - CTRL bit positions
  - master FSM state encoding
  - FRAME_WORDS constant
- One sub-module: fb_word_fifo. Synchronous FIFO, FIFO_DEPTH x 32, with push, pop, full, empty and count. Simultaneous push and pop when full is allowed.

Test Plan:
- PIXEL writes 0x11, 0x22, 0x33, 0x44 with M_PREADY = 1 -> one master write, M_PADDR = 0, M_PWDATA = 0x44332211, M_PSEL 2 cycles after the 4th write, STATUS busy returns to 0.
- 784 PIXEL writes -> exactly 196 master writes at addresses 0..195; frame_done = 1; word pointer = 0; with the macro defined and IRQ_EN = 1, frame_irq = 1.
- M_PREADY held 0 while 40 pixels are written -> M_PENABLE held, address and data stable; fifo_full = 1; overflow = 1; word count = 9 (1 in flight + 8 buffered), remaining word dropped.
- PIXEL 0xAA, 0xBB, then CTRL FLUSH -> M_PWDATA = 0x0000BBAA; lane = 0; a further FLUSH produces no transfer.
- CTRL START while in ACCESS at address 5 with M_PREADY stalled -> address 5 write completes; FIFO cleared; next pixel word goes to address 0.
- PRESETN asserted during ACCESS -> M_PSEL and M_PENABLE = 0 immediately; STATUS = 0 after release.
